// File: rtl/layer_wr_ctl.sv
// layer_wr_ctl
// Write controller for the LED cube frame buffer. Turns the host byte stream
// (command/data bytes qualified by byte_rdy_in) into write enables, a pixel
// address and byte-lane enables for LAYERS layer RAMs plus one config bank.
// Frames start at a selectable layer and walk down to layer 0. Data arriving
// after a complete frame raises a sticky overrun flag.
module layer_wr_ctl #(
    parameter int          LAYERS  = 8,
    parameter int          PIXELS  = 64,
    parameter int          COLORS  = 3,
    parameter logic [7:0]  CONF_WR = 8'h2a,
    parameter logic [7:0]  ADDR_WR = 8'h2b,
    parameter logic [7:0]  DATA_WR = 8'h2c,
    parameter logic [7:0]  LSEL_WR = 8'h2d,
    localparam int         AW      = $clog2(PIXELS)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              dc_in,
    input  logic              byte_rdy_in,
    input  logic [7:0]        byte_data_in,
    output logic              wr_done_out,
    output logic [LAYERS:0]   wr_en_out,
    output logic [AW-1:0]     wr_addr_out,
    output logic [COLORS:0]   wr_byte_en_out,
    output logic              ovf_out
);

    localparam int CW = (COLORS > 1) ? $clog2(COLORS) : 1;
    localparam int LW = $clog2(LAYERS);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CONF = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_LSEL = 3'd4;
    localparam logic [2:0] ST_FULL = 3'd5;

    localparam logic [AW-1:0] ADDR_LAST  = AW'(PIXELS - 1);
    localparam logic [CW-1:0] COLOR_LAST = CW'(COLORS - 1);
    localparam logic [LW-1:0] LAYER_LAST = LW'(LAYERS - 1);

    logic [2:0]    state;
    logic [CW-1:0] c;
    logic [LW-1:0] l;
    logic [LW-1:0] start_layer;

    logic addr_last;
    logic color_last;

    assign addr_last  = (wr_addr_out == ADDR_LAST);
    assign color_last = (c == COLOR_LAST);

    // Decode the byte being offered this cycle into RAM/lane enables; nothing fires without a data strobe
    always_comb begin
        wr_en_out      = '0;
        wr_byte_en_out = '0;
        wr_done_out    = 1'b0;
        if (byte_rdy_in && dc_in) begin
            case (state)
                ST_CONF: begin
                    wr_en_out[LAYERS] = 1'b1;
                end
                ST_ADDR: begin
                    wr_en_out[LAYERS-1:0]  = '1;
                    wr_byte_en_out[COLORS] = 1'b1;
                end
                ST_DATA: begin
                    for (int i = 0; i < LAYERS; i++) begin
                        wr_en_out[i] = (l == LW'(i));
                    end
                    // colour 0 lands on the highest colour lane
                    for (int i = 0; i < COLORS; i++) begin
                        wr_byte_en_out[i] = (c == CW'(COLORS - 1 - i));
                    end
                    wr_done_out = addr_last && color_last && (l == '0);
                end
                default: begin
                end
            endcase
        end
    end

    // Consume one byte per strobe: commands reset the stream position, data bytes advance it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= ST_IDLE;
            wr_addr_out <= '0;
            c           <= '0;
            l           <= '0;
            start_layer <= LAYER_LAST;
            ovf_out     <= 1'b0;
        end else if (byte_rdy_in) begin
            if (!dc_in) begin
                wr_addr_out <= '0;
                c           <= '0;
                ovf_out     <= 1'b0;
                case (byte_data_in)
                    CONF_WR: state <= ST_CONF;
                    ADDR_WR: state <= ST_ADDR;
                    DATA_WR: begin
                        state <= ST_DATA;
                        l     <= start_layer;
                    end
                    LSEL_WR: state <= ST_LSEL;
                    default: state <= ST_IDLE;
                endcase
            end else begin
                case (state)
                    ST_CONF, ST_ADDR: begin
                        if (addr_last) begin
                            wr_addr_out <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            wr_addr_out <= wr_addr_out + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (color_last) begin
                            c <= '0;
                            if (addr_last) begin
                                wr_addr_out <= '0;
                                // layer 0 finishing means the frame is complete; l stays at 0
                                if (l == '0) begin
                                    state <= ST_FULL;
                                end else begin
                                    l <= l - 1'b1;
                                end
                            end else begin
                                wr_addr_out <= wr_addr_out + 1'b1;
                            end
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                    ST_LSEL: begin
                        if (32'(byte_data_in) >= 32'(LAYERS - 1)) begin
                            start_layer <= LAYER_LAST;
                        end else begin
                            start_layer <= LW'(byte_data_in);
                        end
                        state <= ST_IDLE;
                    end
                    ST_FULL: begin
                        ovf_out <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_wr_ctl.sv
// tb_layer_wr_ctl
// Drives layer_wr_ctl with directed command/data sequences followed by a
// random byte stream, and compares every cycle against a byte-count model
// of the frame layout.
module tb_layer_wr_ctl;

    localparam int L = 8;
    localparam int P = 64;
    localparam int C = 3;
    localparam int AW = $clog2(P);

    localparam int M_IDLE = 0;
    localparam int M_CONF = 1;
    localparam int M_ADDR = 2;
    localparam int M_DATA = 3;
    localparam int M_LSEL = 4;
    localparam int M_FULL = 5;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          dc_in;
    logic          byte_rdy_in;
    logic [7:0]    byte_data_in;
    logic          wr_done_out;
    logic [L:0]    wr_en_out;
    logic [AW-1:0] wr_addr_out;
    logic [C:0]    wr_byte_en_out;
    logic          ovf_out;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // reference model: mode plus byte count within the current command
    int mode;
    int k;
    int start_sel;
    int frame_start;
    bit m_ovf;

    layer_wr_ctl #(
        .LAYERS (L),
        .PIXELS (P),
        .COLORS (C)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .dc_in          (dc_in),
        .byte_rdy_in    (byte_rdy_in),
        .byte_data_in   (byte_data_in),
        .wr_done_out    (wr_done_out),
        .wr_en_out      (wr_en_out),
        .wr_addr_out    (wr_addr_out),
        .wr_byte_en_out (wr_byte_en_out),
        .ovf_out        (ovf_out)
    );

    // free-running clock
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mode        = M_IDLE;
        k           = 0;
        start_sel   = L - 1;
        frame_start = 0;
        m_ovf       = 1'b0;
    endtask

    // one cycle: drive at negedge, compare shortly after, then consume at posedge
    task automatic applyStimulus(input bit rdy, input bit dc, input logic [7:0] data);
        logic [L:0]    e_en;
        logic [C:0]    e_be;
        logic          e_done;
        int            e_addr;
        int            lyr;
        @(negedge clk_in);
        byte_rdy_in  = rdy;
        dc_in        = dc;
        byte_data_in = data;
        #1;
        e_en   = '0;
        e_be   = '0;
        e_done = 1'b0;
        if (mode == M_DATA)
            e_addr = (k / C) % P;
        else if (mode == M_CONF || mode == M_ADDR)
            e_addr = k;
        else
            e_addr = 0;
        if (rdy && dc) begin
            case (mode)
                M_CONF: e_en[L] = 1'b1;
                M_ADDR: begin
                    e_en[L-1:0] = '1;
                    e_be[C]     = 1'b1;
                end
                M_DATA: begin
                    lyr          = frame_start - k / (P * C);
                    e_en[lyr]    = 1'b1;
                    e_be[C - 1 - (k % C)] = 1'b1;
                    e_done       = (k == (frame_start + 1) * P * C - 1);
                end
                default: begin
                end
            endcase
        end
        checkOutput("wr_en", 32'(wr_en_out), 32'(e_en));
        checkOutput("byte_en", 32'(wr_byte_en_out), 32'(e_be));
        checkOutput("done", 32'(wr_done_out), 32'(e_done));
        checkOutput("addr", 32'(wr_addr_out), 32'(e_addr));
        checkOutput("ovf", 32'(ovf_out), 32'(m_ovf));
        @(posedge clk_in);
        if (rdy) begin
            if (!dc) begin
                k     = 0;
                m_ovf = 1'b0;
                case (data)
                    8'h2a: mode = M_CONF;
                    8'h2b: mode = M_ADDR;
                    8'h2c: begin
                        mode        = M_DATA;
                        frame_start = start_sel;
                    end
                    8'h2d: mode = M_LSEL;
                    default: mode = M_IDLE;
                endcase
            end else begin
                case (mode)
                    M_CONF, M_ADDR: begin
                        k++;
                        if (k == P) begin
                            k    = 0;
                            mode = M_IDLE;
                        end
                    end
                    M_DATA: begin
                        k++;
                        if (k == (frame_start + 1) * P * C) mode = M_FULL;
                    end
                    M_LSEL: begin
                        start_sel = (int'(data) > L - 1) ? L - 1 : int'(data);
                        mode      = M_IDLE;
                    end
                    M_FULL: m_ovf = 1'b1;
                    default: begin
                    end
                endcase
            end
        end
    endtask

    task automatic sendCmd(input logic [7:0] code);
        applyStimulus(1'b1, 1'b0, code);
    endtask

    task automatic sendData(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 8'($urandom));
    endtask

    // asynchronous reset asserted mid-cycle while a data byte is on the bus
    task automatic pulseReset();
        @(negedge clk_in);
        byte_rdy_in  = 1'b1;
        dc_in        = 1'b1;
        byte_data_in = 8'h5a;
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("rst_wr_en", 32'(wr_en_out), 32'd0);
        checkOutput("rst_byte_en", 32'(wr_byte_en_out), 32'd0);
        checkOutput("rst_done", 32'(wr_done_out), 32'd0);
        checkOutput("rst_addr", 32'(wr_addr_out), 32'd0);
        checkOutput("rst_ovf", 32'(ovf_out), 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        byte_rdy_in = 1'b0;
        dc_in       = 1'b0;
        rst_n_in    = 1'b1;
        modelReset();
    endtask

    initial begin
        logic [7:0] codes [5];
        int r;
        codes[0] = 8'h2a;
        codes[1] = 8'h2b;
        codes[2] = 8'h2c;
        codes[3] = 8'h2d;
        codes[4] = 8'h00;

        rst_n_in     = 1'b0;
        byte_rdy_in  = 1'b0;
        dc_in        = 1'b0;
        byte_data_in = 8'h00;
        modelReset();
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        $display("[TB] reset released");

        // idle state, a data byte with no command is ignored
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h11);

        // full default frame plus two overrun bytes
        sendCmd(8'h2c);
        sendData(L * P * C + 2);

        // config bank: one full plane plus an ignored byte
        sendCmd(8'h2a);
        sendData(P + 1);

        // address map plane
        sendCmd(8'h2b);
        sendData(P);

        // partial frame from layer 2
        sendCmd(8'h2d);
        applyStimulus(1'b1, 1'b1, 8'h02);
        sendCmd(8'h2c);
        sendData(3 * P * C + 1);

        // clamp of an out-of-range start layer
        sendCmd(8'h2d);
        applyStimulus(1'b1, 1'b1, 8'hff);
        sendCmd(8'h2c);
        sendData(4);

        // command aborts a frame, unknown code returns to idle
        sendCmd(8'h2c);
        sendData(100);
        sendCmd(8'h2a);
        sendData(5);
        sendCmd(8'h77);
        sendData(3);

        // reset mid-frame restores the start layer
        sendCmd(8'h2d);
        applyStimulus(1'b1, 1'b1, 8'h01);
        sendCmd(8'h2c);
        sendData(50);
        pulseReset();
        sendData(2);
        sendCmd(8'h2c);
        sendData(3);

        // small frame with gaps between strobes
        sendCmd(8'h2d);
        applyStimulus(1'b1, 1'b1, 8'h00);
        sendCmd(8'h2c);
        for (int i = 0; i < 2 * P * C; i++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b1, 8'($urandom));
            else applyStimulus(1'b1, 1'b1, 8'($urandom));
        end

        // random stream
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 40)
                applyStimulus(1'b0, 1'($urandom), 8'($urandom));
            else if (r < 43)
                sendCmd(codes[$urandom_range(0, 4)]);
            else if (r < 44) begin
                sendCmd(8'h2d);
                applyStimulus(1'b1, 1'b1, 8'($urandom_range(0, 9)));
            end else
                applyStimulus(1'b1, 1'b1, 8'($urandom));
        end

        applyStimulus(1'b0, 1'b0, 8'h00);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
